// File: rtl/srv_line_mem.sv
// Line-fill engine: reads one cache line word by word from a combinational ROM,
// optionally critical-word-first, then returns it after a fixed memory delay.
module srv_line_mem #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned MEM_DELAY = 100,
  parameter int unsigned CWF       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_req_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  output logic              ext_rdy_o,
  output logic              ext_rsp_o,
  output logic [LINE_W-1:0] ext_data_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [WORD_W-1:0] rom_data_i
);

  localparam int unsigned WORDS  = LINE_W / WORD_W;
  localparam int unsigned LINE_B = LINE_W / 8;
  localparam int unsigned WORD_B = WORD_W / 8;
  localparam int unsigned OFS_W  = $clog2(LINE_B);
  localparam int unsigned WB_W   = $clog2(WORD_B);
  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned DLY_W  = 10;

  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((MEM_DELAY > 0) ? MEM_DELAY - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_B - 1);

  if (WORD_W == 0 || (WORD_W % 8) != 0) begin : g_chk_word
    $error("srv_line_mem: WORD_W must be a non-zero multiple of 8");
  end
  if ((LINE_W % WORD_W) != 0) begin : g_chk_line
    $error("srv_line_mem: LINE_W must be a multiple of WORD_W");
  end
  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_chk_words
    $error("srv_line_mem: LINE_W/WORD_W must be a power of two, at least 2");
  end
  if ((LINE_B & (LINE_B - 1)) != 0) begin : g_chk_bytes
    $error("srv_line_mem: LINE_W/8 must be a power of two");
  end
  if (ADDR_W <= OFS_W) begin : g_chk_addr
    $error("srv_line_mem: ADDR_W too narrow for the line offset");
  end
  if (MEM_DELAY > 1023) begin : g_chk_delay
    $error("srv_line_mem: MEM_DELAY must be within 0..1023");
  end
  if (CWF > 1) begin : g_chk_cwf
    $error("srv_line_mem: CWF must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [BEAT_W-1:0] r_start;
  logic [BEAT_W-1:0] r_beat;
  logic [DLY_W-1:0]  r_dly;
  logic [LINE_W-1:0] r_line;

  logic [ADDR_W-1:0] w_req_base;
  logic [BEAT_W-1:0] w_req_start;
  logic [ADDR_W-1:0] w_first_addr;
  logic [BEAT_W-1:0] w_idx;
  logic [BEAT_W-1:0] w_idx_nxt;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_dly_done;

  assign w_req_base   = ext_addr_i & BASE_MASK;
  assign w_req_start  = (CWF != 0) ? ext_addr_i[OFS_W-1:WB_W] : '0;
  assign w_first_addr = w_req_base | (ADDR_W'(w_req_start) << WB_W);

  // Beat-width addition wraps the word index inside the line; base never moves.
  assign w_idx       = r_start + r_beat;
  assign w_idx_nxt   = w_idx + BEAT_W'(1);
  assign w_next_addr = r_base | (ADDR_W'(w_idx_nxt) << WB_W);

  assign w_accept    = (r_state == ST_IDLE) && ext_req_i;
  assign w_last_beat = (r_beat == BEAT_LAST);
  assign w_dly_done  = (r_dly == DLY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ext_rdy_o   = 1'b0;
    ext_rsp_o   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ext_rdy_o = 1'b1;
        if (ext_req_i) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_last_beat) w_state_nxt = (MEM_DELAY > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (w_dly_done) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ext_rsp_o   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // rom_addr_o is registered one beat ahead so the ROM sees it for the whole beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_start    <= '0;
      r_beat     <= '0;
      r_dly      <= '0;
      r_rom_addr <= '0;
      r_line     <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= w_req_base;
        r_start    <= w_req_start;
        r_beat     <= '0;
        r_rom_addr <= w_first_addr;
      end
      if (r_state == ST_FETCH) begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (w_idx == BEAT_W'(i)) r_line[i*WORD_W +: WORD_W] <= rom_data_i;
        end
        r_beat <= r_beat + BEAT_W'(1);
        if (w_last_beat) begin
          r_dly <= '0;
        end else begin
          r_rom_addr <= w_next_addr;
        end
      end
      if (r_state == ST_WAIT) begin
        r_dly <= r_dly + DLY_W'(1);
      end
    end
  end

  assign ext_data_o = r_line;
  assign rom_addr_o = r_rom_addr;

endmodule

// File: tb/tb_srv_line_mem.sv
// Bench for srv_line_mem: three configurations fed by an address-keyed ROM,
// checked against a fill model built from line base, start word and latency rules.
module tb_srv_line_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req [3];
  logic [31:0] addr[3];
  logic        rdy [3];
  logic        rsp [3];
  logic [31:0] ra  [3];
  logic [31:0] rd  [3];
  logic [31:0] key [3];
  logic [127:0] d0;
  logic [255:0] d1;
  logic [127:0] d2;

  int checks = 0;
  int errors = 0;

  srv_line_mem u_a (
    .clk(clk), .rst_n(rst_n), .ext_req_i(req[0]), .ext_addr_i(addr[0]),
    .ext_rdy_o(rdy[0]), .ext_rsp_o(rsp[0]), .ext_data_o(d0),
    .rom_addr_o(ra[0]), .rom_data_i(rd[0])
  );

  srv_line_mem #(.LINE_W(256), .MEM_DELAY(3), .CWF(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ext_req_i(req[1]), .ext_addr_i(addr[1]),
    .ext_rdy_o(rdy[1]), .ext_rsp_o(rsp[1]), .ext_data_o(d1),
    .rom_addr_o(ra[1]), .rom_data_i(rd[1])
  );

  srv_line_mem #(.MEM_DELAY(0), .CWF(1)) u_c (
    .clk(clk), .rst_n(rst_n), .ext_req_i(req[2]), .ext_addr_i(addr[2]),
    .ext_rdy_o(rdy[2]), .ext_rsp_o(rsp[2]), .ext_data_o(d2),
    .rom_addr_o(ra[2]), .rom_data_i(rd[2])
  );

  // ROM word at byte address a is a ^ key; key 0 gives the identity ROM.
  assign rd[0] = ra[0] ^ key[0];
  assign rd[1] = ra[1] ^ key[1];
  assign rd[2] = ra[2] ^ key[2];

  function automatic int nw(int s);
    return (s == 1) ? 8 : 4;
  endfunction

  function automatic int md(int s);
    return (s == 0) ? 100 : ((s == 1) ? 3 : 0);
  endfunction

  function automatic bit cw(int s);
    return (s != 0);
  endfunction

  function automatic logic [255:0] dat(int s);
    if (s == 0) return {128'd0, d0};
    else if (s == 1) return d1;
    else return {128'd0, d2};
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete fill on configuration s, checking every cycle until the idle after RESP.
  task automatic fill(int s, logic [31:0] a);
    int w, m, lb, start, wi, cyc;
    logic [31:0]  base, last;
    logic [255:0] exp_line;
    w  = nw(s);
    m  = md(s);
    lb = w * 4;
    base  = a & ~32'(lb - 1);
    start = cw(s) ? int'((a % lb) / 4) : 0;
    exp_line = '0;
    for (int k = 0; k < w; k++) exp_line[k*32 +: 32] = (base + k * 4) ^ key[s];
    last = base + ((start + w - 1) % w) * 4;
    cyc = 0;
    while (!rdy[s] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rdy_before_req", rdy[s], 1'b1);
    req[s]  = 1'b1;
    addr[s] = a;
    @(posedge clk); #1;
    req[s]  = 1'b0;
    addr[s] = $urandom;
    for (int c = 1; c <= w + m + 2; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (c <= w) begin
        wi = (start + c - 1) % w;
        chk("rom_addr", ra[s], base + wi * 4);
      end else begin
        chk("rom_addr_hold", ra[s], last);
      end
      chk("rsp", rsp[s], (c == w + m + 1));
      chk("rdy", rdy[s], (c == w + m + 2));
      if (c >= w + m + 1) chk("line", dat(s), exp_line);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, pulses;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      addr[i] = '0;
      key[i]  = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdy", rdy[i], 1'b1);
      chk("reset_rsp", rsp[i], 1'b0);
      chk("reset_data", dat(i), '0);
      chk("reset_rom_addr", ra[i], '0);
    end
    @(negedge clk) rst_n = 1'b1;

    fill(0, 32'h0000_0040);
    chk("dflt_line", dat(0), {128'd0, 32'h4C, 32'h48, 32'h44, 32'h40});
    fill(2, 32'h0000_0048);
    chk("cwf_line", dat(2), {128'd0, 32'h4C, 32'h48, 32'h44, 32'h40});
    fill(1, 32'h0000_001F);
    fill(2, 32'h0000_104C);
    fill(1, 32'h0000_2034);

    for (int n = 0; n < 24; n++) begin
      s = $urandom_range(0, 2);
      key[s] = $urandom;
      fill(s, $urandom);
    end

    // continuous request on the zero-delay, 4-word configuration
    key[2]  = $urandom;
    req[2]  = 1'b1;
    addr[2] = $urandom;
    @(posedge clk); #1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk("cont_rsp", rsp[2], (c % 6) == 5);
      chk("cont_rdy", rdy[2], (c % 6) == 0);
      addr[2] = $urandom;
    end
    req[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset during WAIT aborts the default-configuration fill
    req[0]  = 1'b1;
    addr[0] = 32'h0000_0100;
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_wait_rdy", rdy[0], 1'b1);
    chk("abort_wait_rsp", rsp[0], 1'b0);
    chk("abort_wait_data", dat(0), '0);
    chk("abort_wait_rom_addr", ra[0], '0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (rsp[0]) pulses++;
    end
    chk("abort_wait_no_rsp", pulses, 0);
    chk("abort_wait_data_hold", dat(0), '0);
    chk("abort_wait_rdy_after", rdy[0], 1'b1);

    // reset during FETCH on the 8-word configuration
    req[1]  = 1'b1;
    addr[1] = $urandom;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_fetch_data", dat(1), '0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp[1]) pulses++;
    end
    chk("abort_fetch_no_rsp", pulses, 0);

    // request presented as reset releases is taken on the first edge
    rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
    key[0] = $urandom;
    fill(0, $urandom);
    key[1] = $urandom;
    fill(1, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
